// File: rtl/matrix_pkg.sv
// Shared types and constants for the 8x8 RGB matrix scan driver.
// Colour data is active-low everywhere: a set bit means the LED is off.
package matrix_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam logic [COLS-1:0] LED_OFF = 8'hFF;

  typedef struct packed {
    logic [COLS-1:0] r;
    logic [COLS-1:0] g;
    logic [COLS-1:0] b;
  } rgb_row_t;

  typedef rgb_row_t [ROWS-1:0] frame_t;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/matrix_scan_driver_row_timer.sv
// Row slot timer: counts 0..ROW_PERIOD-1, flags the last cycle of the slot (wrap)
// and whether the current cycle lies in the leading blank window.
module row_timer #(
  parameter int ROW_PERIOD   = 16,
  parameter int BLANK_CYCLES = 4,
  parameter int TW           = (ROW_PERIOD < 2) ? 1 : $clog2(ROW_PERIOD)
) (
  input  logic          CLK,
  input  logic          reset,
  output logic [TW-1:0] count,
  output logic          wrap,
  output logic          in_blank
);

  if (ROW_PERIOD < 2) begin : g_bad_period
    $error("row_timer: ROW_PERIOD must be at least 2");
  end
  if (BLANK_CYCLES >= ROW_PERIOD) begin : g_bad_blank
    $error("row_timer: BLANK_CYCLES must be smaller than ROW_PERIOD");
  end

  localparam logic [TW-1:0] LAST    = TW'(ROW_PERIOD - 1);
  localparam logic [TW:0]   BLANK_W = (TW + 1)'(BLANK_CYCLES);

  assign wrap     = (count == LAST);
  assign in_blank = ({1'b0, count} < BLANK_W);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (wrap) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/matrix_scan_driver.sv
// Double-buffered 8x8 RGB scan driver: rows are written into a back buffer, buffers
// swap only at the row 7 -> row 0 boundary, and each row slot starts with a blank window.
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int CLK_HZ       = 50_000_000,
  parameter int ROW_HZ       = 8_000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [2:0] wr_row,
  input  logic [7:0] wr_r,
  input  logic [7:0] wr_g,
  input  logic [7:0] wr_b,
  input  logic       swap_req,
  output logic       swap_ack,
  output logic       frame_tick,
  output logic [2:0] s,
  output logic [7:0] OR,
  output logic [7:0] OG,
  output logic [7:0] OB,
  output logic       EN
);

  localparam int ROW_PERIOD = CLK_HZ / ROW_HZ;
  localparam int TW         = (ROW_PERIOD < 2) ? 1 : $clog2(ROW_PERIOD);
  localparam logic [TW-1:0] BLANK_LAST = TW'(BLANK_CYCLES - 1);

  logic [TW-1:0] count;
  logic          wrap;
  logic          in_blank;
  scan_state_t   state;
  scan_state_t   state_next;
  logic [2:0]    s_next;
  logic          boundary;
  logic          pending;
  logic          sel;
  frame_t        buf_a;
  frame_t        buf_b;
  rgb_row_t      show_row;

  row_timer #(
    .ROW_PERIOD  (ROW_PERIOD),
    .BLANK_CYCLES(BLANK_CYCLES),
    .TW          (TW)
  ) u_row_timer (
    .CLK     (CLK),
    .reset   (reset),
    .count   (count),
    .wrap    (wrap),
    .in_blank(in_blank)
  );

  assign s_next   = wrap ? s + 3'd1 : s;
  assign boundary = wrap && (s == 3'd7);
  assign show_row = sel ? buf_b[s_next] : buf_a[s_next];

  always_comb begin
    state_next = state;
    case (state)
      BLANK:   if (in_blank && count == BLANK_LAST) state_next = SHOW;
      SHOW:    if (wrap) state_next = BLANK;
      default: state_next = BLANK;
    endcase
  end

  // sel picks the front buffer; writes always go to the other one, using sel
  // before any same-cycle swap so they land in the buffer about to be shown.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      buf_a <= {ROWS{LED_OFF, LED_OFF, LED_OFF}};
      buf_b <= {ROWS{LED_OFF, LED_OFF, LED_OFF}};
    end else if (wr_en) begin
      if (sel) buf_a[wr_row] <= '{r: wr_r, g: wr_g, b: wr_b};
      else     buf_b[wr_row] <= '{r: wr_r, g: wr_g, b: wr_b};
    end
  end

  // Outputs are loaded from next-cycle state so the row select and the first
  // blank cycle change on the same edge.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state      <= BLANK;
      s          <= 3'd0;
      OR         <= LED_OFF;
      OG         <= LED_OFF;
      OB         <= LED_OFF;
      EN         <= 1'b0;
      swap_ack   <= 1'b0;
      frame_tick <= 1'b0;
      pending    <= 1'b0;
      sel        <= 1'b0;
    end else begin
      state      <= state_next;
      s          <= s_next;
      EN         <= 1'b1;
      frame_tick <= boundary;
      swap_ack   <= boundary && pending;
      pending    <= boundary ? swap_req : (pending || swap_req);
      if (boundary && pending) sel <= ~sel;
      if (state_next == SHOW) begin
        OR <= show_row.r;
        OG <= show_row.g;
        OB <= show_row.b;
      end else begin
        OR <= LED_OFF;
        OG <= LED_OFF;
        OB <= LED_OFF;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scan_driver.sv
// Directed bench for matrix_scan_driver with ROW_PERIOD=16, BLANK_CYCLES=4:
// edge k after reset release has timer k%16 and row (k/16)%8.
module tb_matrix_scan_driver;
  import matrix_pkg::*;

  logic       CLK = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [2:0] wr_row = 3'd0;
  logic [7:0] wr_r = 8'hFF, wr_g = 8'hFF, wr_b = 8'hFF;
  logic       swap_req = 1'b0;
  logic       swap_ack, frame_tick, EN;
  logic [2:0] s;
  logic [7:0] OR, OG, OB;

  matrix_scan_driver #(
    .CLK_HZ(1600), .ROW_HZ(100), .BLANK_CYCLES(4)
  ) dut (
    .CLK(CLK), .reset(reset), .wr_en(wr_en), .wr_row(wr_row),
    .wr_r(wr_r), .wr_g(wr_g), .wr_b(wr_b), .swap_req(swap_req),
    .swap_ack(swap_ack), .frame_tick(frame_tick), .s(s),
    .OR(OR), .OG(OG), .OB(OB), .EN(EN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         edge_n;
    logic       wr;
    logic [2:0] row;
    logic [7:0] r, g, b;
    logic       swap;
  } stim_t;

  typedef struct {
    int         edge_n;
    logic [2:0] s;
    logic [7:0] r, g, b;
    logic       ack, tick;
  } chk_t;

  stim_t stim_q[$];
  chk_t  chk_q[$];
  int    ack_edges[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h, want %0h", name, k, act, exp);
    end
  endtask

  task automatic add_stim(input int k, input logic wr, input logic [2:0] row,
                          input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                          input logic swap);
    stim_t t;
    t.edge_n = k; t.wr = wr; t.row = row; t.r = r; t.g = g; t.b = b; t.swap = swap;
    stim_q.push_back(t);
  endtask

  task automatic add_chk(input int k, input logic [2:0] sv, input logic [7:0] r,
                         input logic [7:0] g, input logic [7:0] b,
                         input logic ack, input logic tick);
    chk_t c;
    c.edge_n = k; c.s = sv; c.r = r; c.g = g; c.b = b; c.ack = ack; c.tick = tick;
    chk_q.push_back(c);
  endtask

  task automatic run(input int last);
    for (int k = 1; k <= last; k++) begin
      wr_en = 1'b0;
      swap_req = 1'b0;
      foreach (stim_q[i]) begin
        if (stim_q[i].edge_n == k) begin
          wr_en = stim_q[i].wr; wr_row = stim_q[i].row;
          wr_r = stim_q[i].r; wr_g = stim_q[i].g; wr_b = stim_q[i].b;
          swap_req = stim_q[i].swap;
        end
      end
      @(posedge CLK);
      #1;
      if (swap_ack) ack_edges.push_back(k);
      foreach (chk_q[i]) begin
        if (chk_q[i].edge_n == k) begin
          check("s", k, 32'(s), 32'(chk_q[i].s));
          check("OR", k, 32'(OR), 32'(chk_q[i].r));
          check("OG", k, 32'(OG), 32'(chk_q[i].g));
          check("OB", k, 32'(OB), 32'(chk_q[i].b));
          check("swap_ack", k, 32'(swap_ack), 32'(chk_q[i].ack));
          check("frame_tick", k, 32'(frame_tick), 32'(chk_q[i].tick));
          check("EN", k, 32'(EN), 32'd1);
        end
      end
    end
    wr_en = 1'b0;
    swap_req = 1'b0;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_OR"}, 0, 32'(OR), 32'hFF);
    check({tag, "_OG"}, 0, 32'(OG), 32'hFF);
    check({tag, "_OB"}, 0, 32'(OB), 32'hFF);
    check({tag, "_s"}, 0, 32'(s), 32'd0);
    check({tag, "_EN"}, 0, 32'(EN), 32'd0);
    check({tag, "_ack"}, 0, 32'(swap_ack), 32'd0);
    check({tag, "_tick"}, 0, 32'(frame_tick), 32'd0);
  endtask

  int exp_ack1[5] = '{512, 640, 896, 1024, 1152};
  int got;

  initial begin
    // Phase 1: reset, blank scanning, writes, swaps and boundary corner cases
    add_stim(10,   1'b1, 3'd3, 8'h7E, 8'hFF, 8'hFF, 1'b0);
    add_stim(400,  1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    add_stim(600,  1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    add_stim(610,  1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    add_stim(620,  1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    add_stim(800,  1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    add_stim(896,  1'b1, 3'd0, 8'h00, 8'h00, 8'h00, 1'b1);
    add_stim(1040, 1'b1, 3'd5, 8'h00, 8'hFF, 8'hFF, 1'b0);
    add_stim(1041, 1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);

    add_chk(1,    3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(4,    3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(15,   3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(16,   3'd1, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(48,   3'd3, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(56,   3'd3, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(112,  3'd7, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(127,  3'd7, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(128,  3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    add_chk(184,  3'd3, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(256,  3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    add_chk(312,  3'd3, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(384,  3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    add_chk(511,  3'd7, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(512,  3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    add_chk(513,  3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(548,  3'd2, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(563,  3'd3, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(564,  3'd3, 8'h7E, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(575,  3'd3, 8'h7E, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(576,  3'd4, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(640,  3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    add_chk(696,  3'd3, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(768,  3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b1);
    add_chk(896,  3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    add_chk(899,  3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(900,  3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    add_chk(911,  3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    add_chk(952,  3'd3, 8'h7E, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(1024, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    add_chk(1030, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(1080, 3'd3, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(1152, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    add_chk(1156, 3'd0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    add_chk(1208, 3'd3, 8'h7E, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(1240, 3'd5, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0);

    repeat (3) @(posedge CLK);
    #1;
    check_off("in_reset");
    @(negedge CLK);
    reset = 1'b1;
    #1;
    check("EN_before_first_edge", 0, 32'(EN), 32'd0);
    run(1240);

    check("ack_count", 0, 32'(ack_edges.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      got = (i < ack_edges.size()) ? ack_edges[i] : -1;
      check("ack_edge", i, 32'(got), 32'(exp_ack1[i]));
    end

    // Asynchronous reset while row 5 is showing red: outputs drop before the next edge
    #2;
    reset = 1'b0;
    #1;
    check_off("async_reset");
    repeat (2) @(posedge CLK);
    #1;
    check_off("held_reset");

    // Phase 2: after release the buffers are blank, even across a swap
    stim_q.delete();
    chk_q.delete();
    ack_edges.delete();
    add_stim(20, 1'b0, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1);
    add_chk(1,   3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(88,  3'd5, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(128, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b1);
    add_chk(196, 3'd4, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(216, 3'd5, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    add_chk(260, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0);
    @(negedge CLK);
    reset = 1'b1;
    run(270);
    check("ack_count_after_reset", 0, 32'(ack_edges.size()), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
